// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scoreboard-driven D-stage stall/forwarding, MDU busy countdown and eret/EPC interlock.
// Optional HAZ_PERF_CNT_EN adds 32-bit stall-cause counters cnt_data, cnt_md, cnt_eret.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int STAGES  = 3,
  parameter int TNEW_W  = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_wa,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_use,
  input  logic              d_eret,
  input  logic              d_mtc0_epc,
  input  logic              e_md_start,
  input  logic              e_md_div,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_sel_rs,
  output logic [SEL_W-1:0]  fwd_sel_rt,
  output logic              md_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       cnt_data,
  output logic [31:0]       cnt_md,
  output logic [31:0]       cnt_eret
`endif
);
  localparam int MD_W   = $clog2(DIV_LAT + 1);
  localparam int ERET_N = (STAGES < 2) ? STAGES : 2;
  logic [STAGES:1]   r_v;
  logic [STAGES:1]   r_epc;
  logic [REG_AW-1:0] r_wa   [1:STAGES];
  logic [TNEW_W-1:0] r_tnew [1:STAGES];
  logic [MD_W-1:0]   r_md_cnt;
  logic [REG_AW-1:0] w_src  [2];
  logic [TNEW_W-1:0] w_tuse [2];
  logic [SEL_W-1:0]  w_sel  [2];
  logic [1:0]        w_stall_src;
  logic              w_stall_data;
  logic              w_stall_md;
  logic              w_stall_eret;
  assign w_src[0]  = d_rs;
  assign w_src[1]  = d_rt;
  assign w_tuse[0] = d_tuse_rs;
  assign w_tuse[1] = d_tuse_rt;
  // Scan oldest to youngest so the youngest matching writer has the last word.
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      w_sel[o]       = '0;
      w_stall_src[o] = 1'b0;
      for (int k = STAGES; k >= 1; k--)
        if (r_v[k] && r_wa[k] == w_src[o] && w_src[o] != '0) begin
          w_sel[o]       = (r_tnew[k] == '0) ? SEL_W'(k) : '0;
          w_stall_src[o] = (r_tnew[k] != '0) && (w_tuse[o] < r_tnew[k]);
        end
    end
  end
  // epc is only ever set by a real mtc0 (which writes no GRF), so it stands on its own.
  assign w_stall_data = |w_stall_src;
  assign w_stall_md   = d_md_use & (e_md_start | md_busy);
  assign w_stall_eret = d_eret & (|r_epc[ERET_N:1]);
  assign stall        = d_valid & (w_stall_data | w_stall_md | w_stall_eret);
  assign fwd_sel_rs   = w_sel[0];
  assign fwd_sel_rt   = w_sel[1];
  assign md_busy      = (r_md_cnt != '0);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v      <= '0;
      r_epc    <= '0;
      r_md_cnt <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_wa[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else begin
      for (int k = STAGES; k > 1; k--) begin
        r_v[k]    <= r_v[k-1] & ~flush;
        r_epc[k]  <= r_epc[k-1] & ~flush;
        r_wa[k]   <= r_wa[k-1];
        r_tnew[k] <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TNEW_W'(1) : '0;
      end
      r_v[1]    <= ~flush & ~stall & d_valid & d_we & (d_wa != '0);
      r_epc[1]  <= ~flush & ~stall & d_valid & d_mtc0_epc;
      r_wa[1]   <= stall ? '0 : d_wa;
      r_tnew[1] <= stall ? '0 : d_tnew;
      r_md_cnt  <= e_md_start ? (e_md_div ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT))
                              : r_md_cnt - MD_W'(md_busy);
    end
  end
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_data <= '0;
      cnt_md   <= '0;
      cnt_eret <= '0;
    end else begin
      cnt_data <= cnt_data + 32'(d_valid & w_stall_data);
      cnt_md   <= cnt_md + 32'(d_valid & w_stall_md);
      cnt_eret <= cnt_eret + 32'(d_valid & w_stall_eret);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: random + directed stimulus against an in-flight instruction list model.
module tb_hazard_scoreboard;
  localparam int REG_AW = 5, STAGES = 3, TNEW_W = 2, MUL_LAT = 5, DIV_LAT = 10, SEL_W = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic d_valid = 0, d_we = 0, d_md_use = 0, d_eret = 0, d_mtc0_epc = 0;
  logic e_md_start = 0, e_md_div = 0, flush = 0;
  logic [REG_AW-1:0] d_rs = '0, d_rt = '0, d_wa = '0;
  logic [TNEW_W-1:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic stall, md_busy;
  logic [SEL_W-1:0] fwd_sel_rs, fwd_sel_rt;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] cnt_data, cnt_md, cnt_eret;
`endif
  always #5 clk = ~clk;
  hazard_scoreboard #(.REG_AW(REG_AW), .STAGES(STAGES), .TNEW_W(TNEW_W), .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_we(d_we), .d_wa(d_wa), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_eret(d_eret), .d_mtc0_epc(d_mtc0_epc), .e_md_start(e_md_start),
    .e_md_div(e_md_div), .flush(flush), .stall(stall), .fwd_sel_rs(fwd_sel_rs),
    .fwd_sel_rt(fwd_sel_rt), .md_busy(md_busy)
`ifdef HAZ_PERF_CNT_EN
    , .cnt_data(cnt_data), .cnt_md(cnt_md), .cnt_eret(cnt_eret)
`endif
  );
  // An in-flight instruction is remembered by the cycle it entered E; its stage is its age.
  typedef struct { int iss; int wa; int tnew0; bit w; bit epc; } rec_t;
  typedef struct { bit stall; int rs; int rt; bit busy; } exp_t;
  typedef struct { bit rst_n; bit v; int rs; int rt; int tur; int tut; bit we; int wa; int tn;
                   bit mdu; bit eret; bit epc; bit st; bit div; bit fl; } stim_t;
  rec_t  fl_q[$];
  exp_t  exp_q[$];
  exp_t  m;
  stim_t nx;
  int now = 0, busy_until = -1, n_cmp = 0, n_bad = 0;
  bit exp_stall = 0;
  function automatic void look(input int r, input int tuse, output int sel, output bit st);
    sel = 0;
    st  = 0;
    foreach (fl_q[i])
      if (fl_q[i].w && fl_q[i].wa == r && r != 0) begin
        int age = now - fl_q[i].iss;
        int rem = fl_q[i].tnew0 - age;
        if (rem < 0) rem = 0;
        sel = (rem == 0) ? age + 1 : 0;
        st  = (rem > 0) && (tuse < rem);
      end
  endfunction
  function automatic exp_t predict();
    exp_t e;
    bit sr, st2, er;
    look(int'(d_rs), int'(d_tuse_rs), e.rs, sr);
    look(int'(d_rt), int'(d_tuse_rt), e.rt, st2);
    e.busy = (now <= busy_until);
    er = 0;
    foreach (fl_q[i]) if (fl_q[i].epc && now - fl_q[i].iss < 2) er = 1;
    e.stall = d_valid && (sr || st2 || (d_md_use && (e_md_start || e.busy)) || (d_eret && er));
    return e;
  endfunction
  function automatic void model_reset();
    fl_q.delete();
    now = 0;
    busy_until = -1;
  endfunction
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      if (flush) fl_q.delete();
      else if (d_valid && !exp_stall && ((d_we && d_wa != 0) || d_mtc0_epc))
        fl_q.push_back('{now + 1, int'(d_wa), int'(d_tnew), d_we && d_wa != 0, d_mtc0_epc});
      now++;
      while (fl_q.size() > 0 && now - fl_q[0].iss + 1 > STAGES) void'(fl_q.pop_front());
      if (e_md_start) busy_until = now + (e_md_div ? DIV_LAT : MUL_LAT) - 1;
    end
    #1;
    reset = nx.rst_n; d_valid = nx.v; d_rs = REG_AW'(nx.rs); d_rt = REG_AW'(nx.rt);
    d_tuse_rs = TNEW_W'(nx.tur); d_tuse_rt = TNEW_W'(nx.tut); d_we = nx.we;
    d_wa = REG_AW'(nx.wa); d_tnew = TNEW_W'(nx.tn); d_md_use = nx.mdu; d_eret = nx.eret;
    d_mtc0_epc = nx.epc; e_md_start = nx.st; e_md_div = nx.div; flush = nx.fl;
    if (!reset) model_reset();
    e = predict();
    exp_stall = e.stall;
    exp_q.push_back(e);
  endtask
  task automatic idle();
    nx = '{default: 0};
    nx.rst_n = 1;
  endtask
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      n_cmp++;
      if (stall !== m.stall || fwd_sel_rs !== SEL_W'(m.rs) || fwd_sel_rt !== SEL_W'(m.rt)
          || md_busy !== m.busy) begin
        n_bad++;
        $display("FAIL t=%0t stall/rs/rt/busy: got %b/%0d/%0d/%b want %b/%0d/%0d/%b", $time,
                 stall, fwd_sel_rs, fwd_sel_rt, md_busy, m.stall, m.rs, m.rt, m.busy);
      end
    end
  end
  initial begin
    nx = '{default: 0};
    step(); step();
    idle(); step();
    // load-use on $8, held in D while stalled
    idle(); nx.v = 1; nx.we = 1; nx.wa = 8; nx.tn = 2; step();
    idle(); nx.v = 1; nx.rs = 8; nx.tur = 1; nx.we = 1; nx.wa = 9; nx.tn = 1; step(); step(); step();
    idle(); nx.v = 1; nx.rs = 9; nx.rt = 0; step(); step();
    // two writers to $10, youngest still pending
    idle(); nx.v = 1; nx.we = 1; nx.wa = 10; nx.tn = 1; step();
    idle(); nx.v = 1; nx.we = 1; nx.wa = 10; nx.tn = 3; step();
    idle(); nx.v = 1; nx.rs = 10; nx.rt = 10; nx.tur = 0; nx.tut = 3; step(); step();
    // divide then mflo
    idle(); nx.st = 1; nx.div = 1; step();
    idle(); nx.v = 1; nx.mdu = 1; repeat (13) step();
    // mtc0 EPC then eret, then the same with a flush
    idle(); nx.v = 1; nx.epc = 1; step();
    idle(); nx.v = 1; nx.eret = 1; repeat (4) step();
    idle(); nx.v = 1; nx.epc = 1; step();
    idle(); nx.v = 1; nx.eret = 1; nx.fl = 1; step();
    nx.fl = 0; step(); step();
    for (int i = 0; i < 3000; i++) begin
      if (!(exp_stall && $urandom_range(3) != 0)) begin
        nx.v = ($urandom_range(7) != 0); nx.rs = $urandom_range(3); nx.rt = $urandom_range(3);
        nx.tur = $urandom_range(3); nx.tut = $urandom_range(3); nx.we = $urandom_range(1);
        nx.wa = $urandom_range(3); nx.tn = $urandom_range(3); nx.mdu = ($urandom_range(3) == 0);
        nx.eret = ($urandom_range(7) == 0); nx.epc = ($urandom_range(7) == 0);
      end
      nx.st = ($urandom_range(9) == 0); nx.div = $urandom_range(1);
      nx.fl = ($urandom_range(19) == 0);
      step();
    end
    // asynchronous reset with MDU counting and valid entries
    idle(); nx.st = 1; nx.div = 1; step();
    idle(); nx.v = 1; nx.we = 1; nx.wa = 5; nx.tn = 3; step(); step(); step();
    idle(); nx.rst_n = 0; nx.v = 1; nx.mdu = 1; nx.rs = 5; step();
`ifdef HAZ_PERF_CNT_EN
    n_cmp++;
    if (cnt_md !== 32'd0) begin
      n_bad++;
      $display("FAIL cnt_md in reset: got %0d want 0", cnt_md);
    end
`endif
    step();
    idle(); step(); step();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
